uart_word_tx: RTL and testbench

Return-path transmitter for the host serial link. It accepts 32-bit result words from the sparse-matrix datapath over a valid/ready handshake and buffers them in a small FIFO. It serializes each word as four 8N1 UART frames on TxD, least-significant byte first. It is the board-to-host counterpart of the host-to-board command receiver.

---
 rtl/uart_word_tx.sv | 190 +++++++++++++++++++
 tb/tb_uart_word_tx.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_word_tx.sv
// uart_word_tx: return-path serial transmitter for the host link.
// 32-bit words arrive over valid/ready into a small FIFO and are sent as
// four 8N1 frames, least-significant byte first, with no gap between frames
// of a word or between back-to-back words.
module uart_word_tx #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200,
    parameter int DEPTH    = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     word_valid,
    input  logic [31:0]              word_data,
    output logic                     word_ready,
    output logic                     TxD,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int DIV = CLK_FREQ / BAUD;
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = PW + 1;
    localparam int BW  = $clog2(DIV);

    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [BW-1:0] BAUD_ZERO = {BW{1'b0}};
    localparam logic [BW-1:0] BAUD_ONE  = {{(BW-1){1'b0}}, 1'b1};
    localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t          state_r;
    logic [BW-1:0]   baud_cnt_r;
    logic [2:0]      bit_idx_r;
    logic [1:0]      byte_idx_r;
    logic [31:0]     shift_r;
    logic            txd_r;
    logic            busy_r;
    logic            word_ready_r;
    logic [CW-1:0]   count_r;
    logic [PW-1:0]   rd_ptr_r;
    logic [PW-1:0]   wr_ptr_r;
    logic [31:0]     mem_r [DEPTH];

    logic            baud_last_s;
    logic            word_end_s;
    logic            fifo_nonempty_s;
    logic            push_s;
    logic            pop_s;
    logic            going_idle_s;
    logic            txd_next_s;
    logic [CW-1:0]   count_next_s;

    assign word_ready = word_ready_r;
    assign TxD        = txd_r;
    assign busy       = busy_r;
    assign fifo_count = count_r;

    // Handshake, pop decision, next FIFO occupancy and next line level.
    always_comb begin
        baud_last_s     = (baud_cnt_r == BAUD_LAST);
        word_end_s      = (state_r == STOP) && baud_last_s && (byte_idx_r == 2'd3);
        fifo_nonempty_s = (count_r != CNT_ZERO);
        push_s          = word_valid && word_ready_r;
        pop_s           = fifo_nonempty_s && ((state_r == IDLE) || word_end_s);
        going_idle_s    = !fifo_nonempty_s && ((state_r == IDLE) || word_end_s);

        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_ONE;
            2'b01:   count_next_s = count_r - CNT_ONE;
            default: count_next_s = count_r;
        endcase

        txd_next_s = 1'b1;
        case (state_r)
            IDLE:    txd_next_s = 1'b1;
            START:   txd_next_s = 1'b0;
            DATA:    txd_next_s = shift_r[{byte_idx_r, bit_idx_r}];
            STOP:    txd_next_s = 1'b1;
            default: txd_next_s = 1'b1;
        endcase
    end

    // FIFO storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= word_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            count_r  <= CNT_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_next_s;
        end
    end

    // Frame sequencer with registered line, ready and busy outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            baud_cnt_r   <= BAUD_ZERO;
            bit_idx_r    <= 3'd0;
            byte_idx_r   <= 2'd0;
            shift_r      <= 32'd0;
            txd_r        <= 1'b1;
            busy_r       <= 1'b0;
            word_ready_r <= 1'b0;
        end else begin
            txd_r        <= txd_next_s;
            word_ready_r <= (count_next_s < CNT_FULL);
            busy_r       <= !going_idle_s || (count_next_s != CNT_ZERO);
            case (state_r)
                IDLE: begin
                    baud_cnt_r <= BAUD_ZERO;
                    if (fifo_nonempty_s) begin
                        shift_r    <= mem_r[rd_ptr_r];
                        byte_idx_r <= 2'd0;
                        state_r    <= START;
                    end else begin
                        state_r    <= IDLE;
                    end
                end
                START: begin
                    if (baud_last_s) begin
                        baud_cnt_r <= BAUD_ZERO;
                        bit_idx_r  <= 3'd0;
                        state_r    <= DATA;
                    end else begin
                        baud_cnt_r <= baud_cnt_r + BAUD_ONE;
                    end
                end
                DATA: begin
                    if (baud_last_s) begin
                        baud_cnt_r <= BAUD_ZERO;
                        if (bit_idx_r == 3'd7) begin
                            state_r <= STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + BAUD_ONE;
                    end
                end
                STOP: begin
                    if (baud_last_s) begin
                        baud_cnt_r <= BAUD_ZERO;
                        if (byte_idx_r != 2'd3) begin
                            byte_idx_r <= byte_idx_r + 2'd1;
                            state_r    <= START;
                        end else if (fifo_nonempty_s) begin
                            // Chain the next word straight into its start bit.
                            shift_r    <= mem_r[rd_ptr_r];
                            byte_idx_r <= 2'd0;
                            state_r    <= START;
                        end else begin
                            state_r    <= IDLE;
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + BAUD_ONE;
                    end
                end
                default: begin
                    baud_cnt_r <= BAUD_ZERO;
                    state_r    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_word_tx.sv
// Testbench for uart_word_tx: directed words, a serial-line monitor that
// decodes frames and checks them against a byte scoreboard, plus timing checks.
module tb_uart_word_tx;

    localparam int CLK_FREQ = 16;
    localparam int BAUD     = 1;
    localparam int DEPTH    = 8;
    localparam int DIV      = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        word_valid;
    logic [31:0] word_data;
    logic        word_ready;
    logic        txd;
    logic        busy;
    logic [3:0]  fifo_count;

    uart_word_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .word_valid (word_valid),
        .word_data  (word_data),
        .word_ready (word_ready),
        .TxD        (txd),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    int frame_starts[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic int start_at(input int idx);
        if (idx < frame_starts.size()) return frame_starts[idx];
        return -1;
    endfunction

    // Line monitor: samples mid-bit, decodes each frame, compares with scoreboard.
    int         mon_t;
    int         mon_k;
    bit         mon_active = 1'b0;
    logic [7:0] mon_byte;
    logic [7:0] exp_b;
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_active = 1'b0;
            exp_q.delete();
        end else if (!mon_active) begin
            if (txd == 1'b0) begin
                mon_active = 1'b1;
                mon_t = 0;
                frame_starts.push_back(cyc);
            end
        end else begin
            mon_t++;
            if (mon_t % DIV == DIV / 2) begin
                mon_k = mon_t / DIV;
                if (mon_k == 0) begin
                    chk("start_bit", {31'd0, txd}, 32'd0);
                end else if (mon_k <= 8) begin
                    mon_byte[mon_k-1] = txd;
                end else begin
                    chk("stop_bit", {31'd0, txd}, 32'd1);
                    mon_active = 1'b0;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame actual=%h expected=none", mon_byte);
                    end else begin
                        exp_b = exp_q.pop_front();
                        chk("rx_byte", {24'd0, mon_byte}, {24'd0, exp_b});
                    end
                end
            end
        end
    end

    // Offer a word, scramble data while refused, push when ready; returns push edge.
    task automatic push_word(input logic [31:0] w, output int edge_no);
        int tmo;
        tmo = 0;
        @(negedge clk);
        word_valid = 1'b1;
        while (!word_ready && tmo < 20000) begin
            word_data = ~w ^ tmo;
            @(negedge clk);
            tmo++;
        end
        word_data = w;
        if (!word_ready) begin
            checks++;
            errors++;
            $display("FAIL push_timeout actual=not_ready expected=ready word=%h", w);
            edge_no = -1;
            word_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            word_valid = 1'b0;
            edge_no = cyc;
            for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
        end
    endtask

    task automatic wait_idle(output int drop_edge);
        int tmo;
        tmo = 0;
        @(negedge clk);
        while (busy && tmo < 20000) begin
            @(negedge clk);
            tmo++;
        end
        drop_edge = cyc;
        chk("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_negedge_at(input int k);
        while (cyc < k) @(negedge clk);
    endtask

    initial begin
        int e, e1, e9, d, f, n0, n1, bad, idx, wn;
        logic [31:0] w;
        rst_n = 1'b0;
        word_valid = 1'b0;
        word_data = 32'd0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_txd", {31'd0, txd}, 32'd1);
        chk("rst_ready", {31'd0, word_ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_count", {28'd0, fifo_count}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_ready", {31'd0, word_ready}, 32'd1);

        // Latency from push to start bit
        n0 = frame_starts.size();
        push_word(32'h0000_00FF, e);
        chk("lat_count1", {28'd0, fifo_count}, 32'd1);
        chk("lat_busy", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        chk("lat_count0", {28'd0, fifo_count}, 32'd0);
        chk("lat_txd_hi", {31'd0, txd}, 32'd1);
        @(posedge clk); #1;
        chk("lat_txd_fall", {31'd0, txd}, 32'd0);
        wait_idle(d);
        chk("lat_start_edge", start_at(n0), e + 2);
        chk("lat_busy_drop", d, e + 2 + 40*DIV - 1);

        // Single word: byte order, frame spacing, total length
        n0 = frame_starts.size();
        push_word(32'hA5C3_0F81, e);
        wait_idle(d);
        f = start_at(n0);
        chk("single_frames", frame_starts.size() - n0, 32'd4);
        for (int j = 1; j < 4; j++)
            chk("single_spacing", start_at(n0 + j) - start_at(n0 + j - 1), 10*DIV);
        chk("single_len", d - f + 1, 40*DIV);
        repeat (20) @(negedge clk);
        chk("single_txd_idle", {31'd0, txd}, 32'd1);

        // Fill to full, held word accepted after next pop
        n0 = frame_starts.size();
        e1 = 0;
        e9 = 0;
        for (int i = 0; i < 10; i++) begin
            push_word(i, e);
            if (i == 1) begin
                e1 = e;
                chk("fill_pushpop_count", {28'd0, fifo_count}, 32'd1);
            end
            if (i == 8) begin
                chk("fill_full_count", {28'd0, fifo_count}, 32'd8);
                chk("fill_full_ready", {31'd0, word_ready}, 32'd0);
            end
            if (i == 9) e9 = e;
        end
        chk("fill_accept_edge", e9, e1 + 40*DIV + 1);
        wait_idle(d);
        chk("fill_frames", frame_starts.size() - n0, 32'd40);
        bad = 0;
        for (int j = 1; j < 40; j++)
            if (start_at(n0 + j) - start_at(n0 + j - 1) != 10*DIV) bad++;
        chk("fill_no_gap", bad, 32'd0);

        // Simultaneous push and pop at count 3
        n0 = frame_starts.size();
        push_word(32'h1111_1111, e);
        e1 = e;
        push_word(32'h2222_2222, e);
        push_word(32'h3333_3333, e);
        push_word(32'h4444_4444, e);
        chk("sim_pre_count", {28'd0, fifo_count}, 32'd3);
        wait_negedge_at(e1 + 40*DIV);
        chk("sim_pre_ready", {31'd0, word_ready}, 32'd1);
        word_valid = 1'b1;
        word_data = 32'h5566_7788;
        @(posedge clk); #1;
        word_valid = 1'b0;
        for (int b = 0; b < 4; b++) exp_q.push_back(word_data[8*b +: 8]);
        chk("sim_count", {28'd0, fifo_count}, 32'd3);
        wait_idle(d);
        chk("sim_frames", frame_starts.size() - n0, 32'd20);
        chk("sim_word2_start", start_at(n0 + 4) - start_at(n0), 40*DIV);

        // Reset mid-frame during bit 4 of byte 2
        n0 = frame_starts.size();
        push_word(32'h1100_3456, e);
        push_word(32'hCAFE_0001, d);
        push_word(32'hCAFE_0002, d);
        f = e + 2;
        wait_negedge_at(f + 20*DIV + 5*DIV + DIV/2);
        chk("rst_pre_txd", {31'd0, txd}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_txd", {31'd0, txd}, 32'd1);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_count", {28'd0, fifo_count}, 32'd0);
        chk("rst_mid_ready", {31'd0, word_ready}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        n1 = frame_starts.size();
        repeat (700) @(negedge clk);
        chk("rst_no_stale", frame_starts.size() - n1, 32'd0);
        chk("rst_busy_after", {31'd0, busy}, 32'd0);
        n1 = frame_starts.size();
        push_word(32'hDEAD_BEEF, e);
        wait_idle(d);
        chk("rst_new_frames", frame_starts.size() - n1, 32'd4);

        // Pointer wrap: 3*DEPTH+3 words in bursts of 5
        n0 = frame_starts.size();
        idx = 0;
        for (int b = 0; b < 6; b++) begin
            wn = (b < 5) ? 5 : 2;
            for (int j = 0; j < wn; j++) begin
                w = {idx[7:0], ~idx[7:0], idx[7:0] ^ 8'h5A, idx[7:0] + 8'h40};
                push_word(w, e);
                idx++;
            end
            wait_idle(d);
        end
        chk("wrap_words", idx, 3*DEPTH + 3);
        chk("wrap_frames", frame_starts.size() - n0, 4*(3*DEPTH + 3));
        chk("sb_empty", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog actual=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
